kbd_scan_ctrl: RTL and testbench

PS/2 scan-code sequencer between the `ps2_keyboard` receiver FIFO and display/consumer logic. It drains the receiver one byte at a time and parses the Set-2 prefix bytes `F0` (break) and `E0` (extended). Each complete sequence becomes one key event, delivered on a valid/ready output handshake. It also tracks key-held state, counts distinct key presses and flags protocol errors.

---
 rtl/kbd_pkg.sv | 70 +++++++
 rtl/kbd_scan2ascii.sv | 11 +
 rtl/kbd_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_kbd_scan_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared PS/2 Set-2 definitions: prefix byte values, sequencer states, byte
// classification and the a-z scan-code lookup (also usable by display logic).
package kbd_pkg;

  localparam logic [7:0] KBD_BREAK = 8'hF0;
  localparam logic [7:0] KBD_EXT   = 8'hE0;
  localparam logic [7:0] KBD_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_EMIT
  } kbd_state_t;

  typedef enum logic [1:0] {
    BYTE_KEY,
    BYTE_BRK,
    BYTE_EXT,
    BYTE_BAD
  } kbd_byte_t;

  // 00/FF are keyboard error/overrun codes; E1 starts the Pause sequence we do not decode.
  function automatic kbd_byte_t classify_byte(input logic [7:0] code);
    kbd_byte_t kind;
    if (code == KBD_EXT)
      kind = BYTE_EXT;
    else if (code == KBD_BREAK)
      kind = BYTE_BRK;
    else if (code == KBD_PAUSE || code == 8'h00 || code == 8'hFF)
      kind = BYTE_BAD;
    else
      kind = BYTE_KEY;
    return kind;
  endfunction

  function automatic logic [7:0] scan2ascii(input logic [7:0] code);
    logic [7:0] ascii;
    case (code)
      8'h1C:   ascii = 8'h61; // a
      8'h32:   ascii = 8'h62;
      8'h21:   ascii = 8'h63;
      8'h23:   ascii = 8'h64;
      8'h24:   ascii = 8'h65;
      8'h2B:   ascii = 8'h66;
      8'h34:   ascii = 8'h67;
      8'h33:   ascii = 8'h68;
      8'h43:   ascii = 8'h69;
      8'h3B:   ascii = 8'h6A;
      8'h42:   ascii = 8'h6B;
      8'h4B:   ascii = 8'h6C;
      8'h3A:   ascii = 8'h6D;
      8'h31:   ascii = 8'h6E;
      8'h44:   ascii = 8'h6F;
      8'h4D:   ascii = 8'h70;
      8'h15:   ascii = 8'h71;
      8'h2D:   ascii = 8'h72;
      8'h1B:   ascii = 8'h73;
      8'h2C:   ascii = 8'h74;
      8'h3C:   ascii = 8'h75;
      8'h2A:   ascii = 8'h76;
      8'h1D:   ascii = 8'h77;
      8'h22:   ascii = 8'h78;
      8'h35:   ascii = 8'h79;
      8'h1A:   ascii = 8'h7A; // z
      default: ascii = 8'h00;
    endcase
    return ascii;
  endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational Set-2 letter lookup; returns lowercase ASCII or 0 for non-letters.
module kbd_scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] i_code,
  output logic [7:0] o_ascii
);

  assign o_ascii = scan2ascii(i_code);

endmodule

// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-code sequencer: drains the receiver FIFO, folds E0/F0 prefixes into
// one key event per sequence, tracks the held key, counts presses, flags errors.
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int COUNT_W = 8
)
(
  input  logic               clk,
  input  logic               clrn,
  input  logic [7:0]         rx_data,
  input  logic               rx_ready,
  input  logic               rx_overflow,
  output logic               rx_pop,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [7:0]         ev_code,
  output logic [7:0]         ev_ascii,
  output logic               ev_release,
  output logic               ev_ext,
  output logic               key_down,
  output logic [COUNT_W-1:0] press_cnt,
  output logic               err
);

  kbd_state_t         r_state;
  logic [7:0]         r_byte;
  logic               r_brk;
  logic               r_ext;
  logic               r_ev_valid;
  logic [7:0]         r_ev_code;
  logic [7:0]         r_ev_ascii;
  logic               r_ev_release;
  logic               r_ev_ext;
  logic               r_key_down;
  logic [7:0]         r_held_code;
  logic [COUNT_W-1:0] r_press_cnt;
  logic               r_err;

  kbd_byte_t          w_byte_kind;
  logic [7:0]         w_ascii;
  logic               w_new_press;
  logic               w_held_break;

  kbd_scan2ascii u_scan2ascii (
    .i_code  (r_byte),
    .o_ascii (w_ascii)
  );

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_byte_kind  = classify_byte(r_byte);
    w_new_press  = !r_brk && !r_ext && (!r_key_down || (r_byte != r_held_code));
    w_held_break = r_brk && !r_ext && (r_byte == r_held_code);
  end

  // The pop must land in the same cycle the head byte is sampled, hence combinational.
  assign rx_pop = (r_state == S_IDLE) && rx_ready;

  // NOTE: non-blocking assignments so every decision below sees pre-edge register values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= S_IDLE;
      r_byte       <= 8'h00;
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_ev_valid   <= 1'b0;
      r_ev_code    <= 8'h00;
      r_ev_ascii   <= 8'h00;
      r_ev_release <= 1'b0;
      r_ev_ext     <= 1'b0;
      r_key_down   <= 1'b0;
      r_held_code  <= 8'h00;
      r_press_cnt  <= '0;
      r_err        <= 1'b0;
    end else begin
      if (rx_overflow)
        r_err <= 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (rx_ready) begin
            r_byte  <= rx_data;
            r_state <= S_GAP;
          end
        end

        S_GAP: begin
          r_state <= S_IDLE;
          unique case (w_byte_kind)
            BYTE_EXT: begin
              if (r_ext)
                r_err <= 1'b1;
              r_ext <= 1'b1;
            end
            BYTE_BRK: begin
              if (r_brk)
                r_err <= 1'b1;
              r_brk <= 1'b1;
            end
            BYTE_BAD: begin
              r_err <= 1'b1;
              r_brk <= 1'b0;
              r_ext <= 1'b0;
            end
            BYTE_KEY: begin
              r_ev_code    <= r_byte;
              r_ev_ascii   <= r_ext ? 8'h00 : w_ascii;
              r_ev_release <= r_brk;
              r_ev_ext     <= r_ext;
              r_brk        <= 1'b0;
              r_ext        <= 1'b0;
              r_ev_valid   <= 1'b1;
              r_state      <= S_EMIT;
              // A repeat of the held make code is typematic: event only, no count.
              if (w_new_press) begin
                r_press_cnt <= r_press_cnt + COUNT_W'(1);
                r_key_down  <= 1'b1;
                r_held_code <= r_byte;
              end else if (w_held_break) begin
                r_key_down <= 1'b0;
              end
            end
          endcase
        end

        S_EMIT: begin
          if (ev_ready) begin
            r_ev_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ev_valid   = r_ev_valid;
  assign ev_code    = r_ev_code;
  assign ev_ascii   = r_ev_ascii;
  assign ev_release = r_ev_release;
  assign ev_ext     = r_ev_ext;
  assign key_down   = r_key_down;
  assign press_cnt  = r_press_cnt;
  assign err        = r_err;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Bench for kbd_scan_ctrl: a queue-based receiver FIFO, a byte-stream reference
// parser producing expected events, and directed plus randomized scenarios.
module tb_kbd_scan_ctrl;

  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               clrn = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_ready = 1'b0;
  logic               rx_overflow = 1'b0;
  logic               rx_pop;
  logic               ev_valid;
  logic               ev_ready = 1'b1;
  logic [7:0]         ev_code;
  logic [7:0]         ev_ascii;
  logic               ev_release;
  logic               ev_ext;
  logic               key_down;
  logic [COUNT_W-1:0] press_cnt;
  logic               err;

  kbd_scan_ctrl #(.COUNT_W(COUNT_W)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_overflow (rx_overflow),
    .rx_pop      (rx_pop),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_ascii    (ev_ascii),
    .ev_release  (ev_release),
    .ev_ext      (ev_ext),
    .key_down    (key_down),
    .press_cnt   (press_cnt),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       rel;
    logic       ext;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        got_q[$];
  logic [7:0] fifo_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int last_pop = -10;
  int spacing_viol = 0;
  bit pend = 1'b0;

  bit         m_brk, m_ext, m_down, m_err;
  logic [7:0] m_held;
  int         m_cnt;

  logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] other_codes[4]   = '{8'h75, 8'h5A, 8'h12, 8'h66};
  logic [7:0] bad_codes[3]     = '{8'hE1, 8'h00, 8'hFF};

  // Mid-cycle observation of pops and handshakes.
  always @(negedge clk) begin
    cyc++;
    if (rx_pop) begin
      pops++;
      if (cyc - last_pop < 2)
        spacing_viol++;
      last_pop = cyc;
      pend = 1'b1;
    end
    if (ev_valid && ev_ready)
      got_q.push_back('{code: ev_code, ascii: ev_ascii, rel: ev_release, ext: ev_ext});
  end

  // Receiver FIFO: the head advances in the cycle after a pop.
  always @(posedge clk) begin
    #1;
    if (pend && fifo_q.size() > 0)
      void'(fifo_q.pop_front());
    pend = 1'b0;
    rx_ready = (fifo_q.size() > 0);
    rx_data  = rx_ready ? fifo_q[0] : 8'h00;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_ascii(input logic [7:0] c);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c)
        return 8'h61 + 8'(i);
    return 8'h00;
  endfunction

  // Reference parser: one byte of the Set-2 stream at a time.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      if (m_ext) m_err = 1'b1;
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      if (m_brk) m_err = 1'b1;
      m_brk = 1'b1;
    end else if (b == 8'hE1 || b == 8'h00 || b == 8'hFF) begin
      m_err = 1'b1;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      exp_q.push_back('{code: b, ascii: (m_ext ? 8'h00 : ref_ascii(b)), rel: m_brk, ext: m_ext});
      if (!m_ext) begin
        if (!m_brk) begin
          if (!m_down || b != m_held) begin
            m_cnt++;
            m_down = 1'b1;
            m_held = b;
          end
        end else if (b == m_held) begin
          m_down = 1'b0;
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
  endtask

  task automatic apply_reset();
    tick();
    clrn = 1'b0;
    fifo_q.delete();
    got_q.delete();
    exp_q.delete();
    rx_ready = 1'b0;
    rx_data = 8'h00;
    rx_overflow = 1'b0;
    ev_ready = 1'b1;
    pend = 1'b0;
    pops = 0;
    spacing_viol = 0;
    last_pop = -10;
    m_brk = 1'b0; m_ext = 1'b0; m_down = 1'b0; m_err = 1'b0;
    m_held = 8'h00; m_cnt = 0;
    repeat (2) tick();
    clrn = 1'b1;
    tick();
  endtask

  // Runs the stream to quiescence, then scores events and persistent state.
  task automatic drain_and_score(input string name, input int budget, input bit rand_ready);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      tick();
      n++;
      if (rand_ready) ev_ready = 1'($urandom_range(0, 1));
      if (fifo_q.size() == 0 && !ev_valid) quiet++;
      else quiet = 0;
    end
    ev_ready = 1'b1;
    total++;
    if (quiet < 4) begin
      bad++;
      $display("FAIL %s drain: still busy after %0d cycles", name, n);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s event count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s event %0d: got code=%h ascii=%h rel=%b ext=%b want code=%h ascii=%h rel=%b ext=%b",
                 name, i, got_q[i].code, got_q[i].ascii, got_q[i].rel, got_q[i].ext,
                 exp_q[i].code, exp_q[i].ascii, exp_q[i].rel, exp_q[i].ext);
      end
    end
    total++;
    if (key_down !== m_down || press_cnt !== COUNT_W'(m_cnt) || err !== m_err) begin
      bad++;
      $display("FAIL %s state: got key_down=%b press_cnt=%0d err=%b want %b %0d %b",
               name, key_down, press_cnt, err, m_down, COUNT_W'(m_cnt), m_err);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    tick();
    clrn = 1'b0;
    tick();
    total++;
    if ({rx_pop, ev_valid, ev_code, ev_ascii, ev_release, ev_ext, key_down, press_cnt, err} !== '0) begin
      bad++;
      $display("FAIL reset values: pop=%b valid=%b code=%h ascii=%h rel=%b ext=%b down=%b cnt=%0d err=%b want all 0",
               rx_pop, ev_valid, ev_code, ev_ascii, ev_release, ev_ext, key_down, press_cnt, err);
    end
    clrn = 1'b1;
    repeat (2) tick();
    total++;
    if (ev_valid !== 1'b0 || rx_pop !== 1'b0) begin
      bad++;
      $display("FAIL reset idle: valid=%b pop=%b want 0 0", ev_valid, rx_pop);
    end
  endtask

  task automatic test_single();
    apply_reset();
    send(8'h1C);
    drain_and_score("single", 100, 1'b0);
    total++;
    if (pops !== 1 || ev_code !== 8'h1C || ev_ascii !== 8'h61) begin
      bad++;
      $display("FAIL single: pops=%0d code=%h ascii=%h want 1 1c 61", pops, ev_code, ev_ascii);
    end
  endtask

  task automatic test_typematic();
    apply_reset();
    repeat (3) send(8'h1C);
    drain_and_score("typematic", 200, 1'b0);
    total++;
    if (press_cnt !== COUNT_W'(1) || key_down !== 1'b1) begin
      bad++;
      $display("FAIL typematic: press_cnt=%0d key_down=%b want 1 1", press_cnt, key_down);
    end
  endtask

  task automatic test_make_break();
    apply_reset();
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain_and_score("make_break", 200, 1'b0);
    total++;
    if (key_down !== 1'b0 || ev_release !== 1'b1 || ev_code !== 8'h1C) begin
      bad++;
      $display("FAIL make_break release: key_down=%b rel=%b code=%h want 0 1 1c", key_down, ev_release, ev_code);
    end
    send(8'h32);
    drain_and_score("make_b", 100, 1'b0);
    total++;
    if (ev_ascii !== 8'h62 || press_cnt !== COUNT_W'(2)) begin
      bad++;
      $display("FAIL make_b: ascii=%h press_cnt=%0d want 62 2", ev_ascii, press_cnt);
    end
  endtask

  task automatic test_ext();
    apply_reset();
    send(8'h1C);
    drain_and_score("ext_pre", 100, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain_and_score("ext", 200, 1'b0);
    total++;
    if (ev_code !== 8'h75 || ev_ext !== 1'b1 || ev_release !== 1'b1 || ev_ascii !== 8'h00 ||
        key_down !== 1'b1 || press_cnt !== COUNT_W'(1)) begin
      bad++;
      $display("FAIL ext: code=%h ext=%b rel=%b ascii=%h down=%b cnt=%0d want 75 1 1 00 1 1",
               ev_code, ev_ext, ev_release, ev_ascii, key_down, press_cnt);
    end
  endtask

  task automatic test_backpressure();
    ev_t held;
    int  changes = 0;
    int  n = 0;
    apply_reset();
    ev_ready = 1'b0;
    send(8'h1C); send(8'h32); send(8'h21);
    while (!ev_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (ev_valid !== 1'b1) begin
      bad++;
      $display("FAIL backpressure first event: valid=%b after %0d cycles want 1", ev_valid, n);
    end
    held = '{code: ev_code, ascii: ev_ascii, rel: ev_release, ext: ev_ext};
    repeat (20) begin
      tick();
      if (ev_valid !== 1'b1 || held !== '{code: ev_code, ascii: ev_ascii, rel: ev_release, ext: ev_ext})
        changes++;
    end
    total++;
    if (changes != 0 || pops != 1 || fifo_q.size() != 2) begin
      bad++;
      $display("FAIL backpressure hold: changes=%0d pops=%0d queued=%0d want 0 1 2", changes, pops, fifo_q.size());
    end
    ev_ready = 1'b1;
    drain_and_score("backpressure", 200, 1'b0);
    total++;
    if (pops != 3 || spacing_viol != 0) begin
      bad++;
      $display("FAIL backpressure pops: pops=%0d close_pairs=%0d want 3 0", pops, spacing_viol);
    end
  endtask

  task automatic test_prefix_err();
    apply_reset();
    send(8'hF0); send(8'hF0); send(8'h1C);
    drain_and_score("prefix_err", 200, 1'b0);
    total++;
    if (err !== 1'b1 || ev_release !== 1'b1 || ev_code !== 8'h1C) begin
      bad++;
      $display("FAIL prefix_err: err=%b rel=%b code=%h want 1 1 1c", err, ev_release, ev_code);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send(8'hF0);
    repeat (6) tick();
    apply_reset();
    send(8'h2B);
    drain_and_score("reset_mid", 100, 1'b0);
    total++;
    if (ev_release !== 1'b0 || ev_ascii !== 8'h66 || err !== 1'b0 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: rel=%b ascii=%h err=%b down=%b want 0 66 0 1", ev_release, ev_ascii, err, key_down);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    rx_overflow = 1'b1;
    tick();
    rx_overflow = 1'b0;
    m_err = 1'b1;
    repeat (3) tick();
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL overflow sticky: err=%b want 1", err);
    end
    send(8'h21);
    drain_and_score("overflow", 100, 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 256; i++)
      send((i % 2) ? 8'h32 : 8'h1C);
    drain_and_score("wrap", 4000, 1'b0);
    total++;
    if (press_cnt !== '0 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL wrap: press_cnt=%0d key_down=%b want 0 1", press_cnt, key_down);
    end
  endtask

  task automatic test_random();
    logic [7:0] last_letter;
    int         k;
    apply_reset();
    last_letter = 8'h1C;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 40; i++) begin
        k = $urandom_range(0, 19);
        if (k < 10) begin
          last_letter = letter_codes[$urandom_range(0, 25)];
          send(last_letter);
        end else if (k < 12) send(other_codes[$urandom_range(0, 3)]);
        else if (k < 15)     send(8'hF0);
        else if (k < 17)     send(8'hE0);
        else if (k < 18)     send(bad_codes[$urandom_range(0, 2)]);
        else                 send(last_letter);
      end
      drain_and_score("random", 3000, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_typematic();
    test_make_break();
    test_ext();
    test_backpressure();
    test_prefix_err();
    test_reset_mid();
    test_overflow();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
